seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_scan_driver_if.sv | 31 +++
 rtl/seg_decode.sv | 25 ++
 rtl/seg_scan_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: per-digit segment patterns
// in {g,f,e,d,c,b,a} order, blank/dash codes and the scan FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      DEAD = 2'd2
   } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the scan driver: level-style control/data inputs in,
// registered digit/segment drive and frame pulse out, plus the FSM state for debug.
interface seg_scan_driver_if #(
   parameter int N_DIG = 6
);
   import seg_pkg::*;

   // No handshake: inputs are plain levels sampled every clock, outputs are
   // registered and valid every cycle after reset.
   logic                 enable;
   logic [4*N_DIG-1:0]   digits_bcd;
   logic [N_DIG-1:0]     dp_mask;
   logic [N_DIG-1:0]     blink_mask;
   logic                 lz_en;
   logic                 dash;
   logic [N_DIG-1:0]     dig_n;
   logic [7:0]           seg;
   logic                 frame_done;
   state_t               dbg_state;

   modport master (
      output enable, digits_bcd, dp_mask, blink_mask, lz_en, dash,
      input  dig_n, seg, frame_done, dbg_state
   );

   modport slave (
      input  enable, digits_bcd, dp_mask, blink_mask, lz_en, dash,
      output dig_n, seg, frame_done, dbg_state
   );

endinterface

// File: rtl/seg_decode.sv
// BCD nibble to seven-segment pattern {g..a}; codes 10..15 decode to blank.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: one digit lit per slot with an all-off gap between
// digits, frame-aligned input snapshot, blink, leading-zero suppression and dash override.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int N_DIG        = 6,
   parameter int DIV          = 25000,
   parameter int DEAD_CYC     = 4,
   parameter int BLINK_FRAMES = 64
) (
   input logic              clk,
   input logic              rst,
   seg_scan_driver_if.slave bus
);

   localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int CW = $clog2(DIV + DEAD_CYC + 1);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   state_t             state;
   logic [IW-1:0]      idx;
   logic [CW-1:0]      cnt;
   logic               wrap_pend;
   logic [FW-1:0]      fcnt;
   logic               blink_ph;
   logic [4*N_DIG-1:0] snap_bcd;
   logic [N_DIG-1:0]   snap_dp;
   logic [N_DIG-1:0]   snap_blk;
   logic               snap_lz;
   logic [N_DIG-1:0]   dig_n_q;
   logic [7:0]         seg_q;
   logic               fd_q;

   logic               scanning;
   logic               dwell_end;
   logic               advance;
   logic               last_idx;
   logic               frame_start;
   logic [3:0]         cur_nib;
   logic               cur_dp;
   logic               cur_blk;
   logic               cur_upper_zero;
   logic               zero_run;
   logic [N_DIG-1:0]   dig_sel_n;
   logic [6:0]         dec_seg;
   logic               lz_hit;
   logic [N_DIG-1:0]   dig_n_d;
   logic [7:0]         seg_d;

   assign scanning    = (state == ON) || (state == DEAD);
   assign last_idx    = (idx == IW'(N_DIG - 1));
   assign dwell_end   = ((state == ON) && (cnt == CW'(DIV - 1))) ||
                        ((state == DEAD) && (cnt == CW'(DEAD_CYC - 1)));
   // With no gap configured, the end of an ON dwell steps straight to the next digit.
   assign advance     = dwell_end && ((state == DEAD) || (DEAD_CYC == 0));
   assign frame_start = !scanning || (advance && last_idx);

   // Per-digit selection from the snapshot; zero_run tracks "all digits from the top down to i are 0".
   always_comb begin
      cur_nib        = '0;
      cur_dp         = 1'b0;
      cur_blk        = 1'b0;
      cur_upper_zero = 1'b0;
      zero_run       = 1'b1;
      dig_sel_n      = '1;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         zero_run = zero_run & (snap_bcd[i*4 +: 4] == 4'd0);
         if (idx == IW'(i)) begin
            cur_nib        = snap_bcd[i*4 +: 4];
            cur_dp         = snap_dp[i];
            cur_blk        = snap_blk[i];
            cur_upper_zero = zero_run;
            dig_sel_n[i]   = 1'b0;
         end
      end
   end

   seg_decode u_decode (
      .bcd (cur_nib),
      .seg (dec_seg)
   );

   assign lz_hit = snap_lz && (idx != '0) && cur_upper_zero;

   always_comb begin
      dig_n_d = '1;
      seg_d   = SEG_BLANK;
      if (state == ON) begin
         dig_n_d = dig_sel_n;
         if (bus.dash)
            seg_d = SEG_DASH;
         else if (blink_ph && cur_blk)
            seg_d = SEG_BLANK;
         else
            seg_d = {cur_dp, lz_hit ? 7'd0 : dec_seg};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         wrap_pend <= 1'b0;
      end else if (!bus.enable) begin
         state     <= IDLE;
         wrap_pend <= 1'b0;
      end else begin
         wrap_pend <= 1'b0;
         if (!scanning) begin
            state <= ON;
            idx   <= '0;
            cnt   <= '0;
         end else if (advance) begin
            state <= ON;
            cnt   <= '0;
            if (last_idx) begin
               idx       <= '0;
               wrap_pend <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end else if (dwell_end) begin
            state <= DEAD;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Frame bookkeeping: inputs are captured only at frame start so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_bcd <= '0;
         snap_dp  <= '0;
         snap_blk <= '0;
         snap_lz  <= 1'b0;
         fcnt     <= '0;
         blink_ph <= 1'b0;
      end else if (bus.enable && frame_start) begin
         snap_bcd <= bus.digits_bcd;
         snap_dp  <= bus.dp_mask;
         snap_blk <= bus.blink_mask;
         snap_lz  <= bus.lz_en;
         if (scanning) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
               fcnt     <= '0;
               blink_ph <= ~blink_ph;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !bus.enable) begin
         dig_n_q <= '1;
         seg_q   <= SEG_BLANK;
         fd_q    <= 1'b0;
      end else begin
         dig_n_q <= dig_n_d;
         seg_q   <= seg_d;
         fd_q    <= wrap_pend;
      end
   end

   assign bus.dig_n      = dig_n_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = fd_q;
   assign bus.dbg_state  = state;

endmodule
